// File: rtl/msrh_l1d_rd_bank_arb_if.sv
// Read-request bus between L1D requesters, the bank arbiter and the banked data/tag arrays.
// Zero-latency wiring only; s0 requests and s1 responses have no back-pressure.
interface msrh_l1d_rd_bank_arb_if #(
  parameter int REQ_N   = 4,
  parameter int BANK_N  = 2,
  parameter int PADDR_W = 40,
  parameter int DATA_W  = 128
);
  logic [REQ_N-1:0]               i_s0_valid;
  logic [REQ_N-1:0][PADDR_W-1:0]  i_s0_paddr;
  logic [REQ_N-1:0]               i_s0_h_pri;
  logic [REQ_N-1:0]               o_s1_hit;
  logic [REQ_N-1:0]               o_s1_miss;
  logic [REQ_N-1:0]               o_s1_conflict;
  logic [REQ_N-1:0][DATA_W-1:0]   o_s1_data;
  logic [BANK_N-1:0]              o_bank_s0_valid;
  logic [BANK_N-1:0][PADDR_W-1:0] o_bank_s0_paddr;
  logic [BANK_N-1:0]              i_bank_s1_hit;
  logic [BANK_N-1:0]              i_bank_s1_miss;
  logic [BANK_N-1:0][DATA_W-1:0]  i_bank_s1_data;

  modport master (
    output i_s0_valid, i_s0_paddr, i_s0_h_pri, i_bank_s1_hit, i_bank_s1_miss, i_bank_s1_data,
    input  o_s1_hit, o_s1_miss, o_s1_conflict, o_s1_data, o_bank_s0_valid, o_bank_s0_paddr
  );

  modport slave (
    input  i_s0_valid, i_s0_paddr, i_s0_h_pri, i_bank_s1_hit, i_bank_s1_miss, i_bank_s1_data,
    output o_s1_hit, o_s1_miss, o_s1_conflict, o_s1_data, o_bank_s0_valid, o_bank_s0_paddr
  );
endinterface

// File: rtl/msrh_l1d_rd_bank_arb.sv
// Per-bank L1D read arbiter: starved > h_pri > round-robin; MSRH_L1D_RD_MERGE_EN adds same-line merging.
// Latency: s0 request -> s1 hit/miss/conflict exactly one cycle later.
// Backpressure: none; losers see s1 conflict and must re-issue.
module msrh_l1d_rd_bank_arb #(
  parameter int REQ_N         = 4,
  parameter int BANK_N        = 2,
  parameter int PADDR_W       = 40,
  parameter int LINE_OFFSET_W = 6,
  parameter int DATA_W        = 128,
  parameter int STARVE_MAX    = 7
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  msrh_l1d_rd_bank_arb_if.slave bus
);
  localparam int REQ_W  = $clog2(REQ_N);
  localparam int BANK_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;

  logic [REQ_N-1:0][BANK_W-1:0]  req_bank;
  logic [REQ_N-1:0][3:0]         starve_cnt;
  logic [REQ_N-1:0]              starved;
  logic [BANK_N-1:0][REQ_N-1:0]  tgt;
  logic [BANK_N-1:0][REQ_W-1:0]  rr_ptr;
  logic [BANK_N-1:0]             win_vld;
  logic [BANK_N-1:0]             win_rr;
  logic [BANK_N-1:0][REQ_W-1:0]  win_idx;
  logic [REQ_N-1:0]              grant_d;
  logic [REQ_N-1:0]              conflict_d;
  logic [REQ_N-1:0]              grant_q;
  logic [REQ_N-1:0]              conflict_q;
  logic [REQ_N-1:0][BANK_W-1:0]  bank_q;

  always_comb begin
    req_bank = '0;
    starved  = '0;
    tgt      = '0;
    for (int r = 0; r < REQ_N; r++) begin
      req_bank[r] = (BANK_N > 1) ? bus.i_s0_paddr[r][LINE_OFFSET_W +: BANK_W] : '0;
      starved[r]  = (starve_cnt[r] == 4'(STARVE_MAX));
      for (int b = 0; b < BANK_N; b++) begin
        tgt[b][r] = bus.i_s0_valid[r] && (req_bank[r] == BANK_W'(b));
      end
    end
  end

  // Lowest precedence is evaluated first so higher classes overwrite it;
  // descending scans leave the lowest index / nearest rr position as winner.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = '0;
    win_rr  = '0;
    win_idx = '0;
    for (int b = 0; b < BANK_N; b++) begin
      for (int k = REQ_N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= REQ_N) idx = idx - REQ_N;
        if (tgt[b][idx]) begin
          win_vld[b] = 1'b1;
          win_rr[b]  = 1'b1;
          win_idx[b] = REQ_W'(idx);
        end
      end
      for (int r = REQ_N - 1; r >= 0; r--) begin
        if (tgt[b][r] && bus.i_s0_h_pri[r]) begin
          win_rr[b]  = 1'b0;
          win_idx[b] = REQ_W'(r);
        end
      end
      for (int r = REQ_N - 1; r >= 0; r--) begin
        if (tgt[b][r] && starved[r]) begin
          win_rr[b]  = 1'b0;
          win_idx[b] = REQ_W'(r);
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int r = 0; r < REQ_N; r++) begin
      for (int b = 0; b < BANK_N; b++) begin
        if (win_vld[b] && (win_idx[b] == REQ_W'(r))) grant_d[r] = 1'b1;
      end
`ifdef MSRH_L1D_RD_MERGE_EN
      if (bus.i_s0_valid[r] && win_vld[req_bank[r]] &&
          (bus.i_s0_paddr[r][PADDR_W-1:LINE_OFFSET_W] ==
           bus.i_s0_paddr[win_idx[req_bank[r]]][PADDR_W-1:LINE_OFFSET_W])) begin
        grant_d[r] = 1'b1;
      end
`endif
    end
    conflict_d = bus.i_s0_valid & ~grant_d;
  end

  always_comb begin
    bus.o_bank_s0_valid = win_vld;
    bus.o_bank_s0_paddr = '0;
    for (int b = 0; b < BANK_N; b++) begin
      if (win_vld[b]) bus.o_bank_s0_paddr[b] = bus.i_s0_paddr[win_idx[b]];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant_q    <= '0;
      conflict_q <= '0;
      bank_q     <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      bank_q     <= req_bank;
      for (int b = 0; b < BANK_N; b++) begin
        if (win_vld[b] && win_rr[b]) begin
          rr_ptr[b] <= (win_idx[b] == REQ_W'(REQ_N - 1)) ? '0 : win_idx[b] + 1'b1;
        end
      end
      for (int r = 0; r < REQ_N; r++) begin
        if (!bus.i_s0_valid[r] || grant_d[r]) begin
          starve_cnt[r] <= '0;
        end else if (starve_cnt[r] < 4'(STARVE_MAX)) begin
          starve_cnt[r] <= starve_cnt[r] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    bus.o_s1_hit      = '0;
    bus.o_s1_miss     = '0;
    bus.o_s1_data     = '0;
    bus.o_s1_conflict = conflict_q;
    for (int r = 0; r < REQ_N; r++) begin
      bus.o_s1_hit[r]  = grant_q[r] & bus.i_bank_s1_hit[bank_q[r]];
      bus.o_s1_miss[r] = grant_q[r] & bus.i_bank_s1_miss[bank_q[r]];
      if (grant_q[r]) bus.o_s1_data[r] = bus.i_bank_s1_data[bank_q[r]];
    end
  end
endmodule

// File: tb/tb_msrh_l1d_rd_bank_arb.sv
// Directed bench for msrh_l1d_rd_bank_arb: stimulus pushes expected s1 responses, a monitor pops and compares.
module tb_msrh_l1d_rd_bank_arb;
  localparam int REQ_N = 4;
  localparam int BANK_N = 2;
  localparam int PADDR_W = 40;
  localparam int DATA_W = 64;
  localparam logic [63:0] D0 = {8{8'hA5}};
  localparam logic [63:0] D1 = {8{8'h3C}};

  typedef struct {
    logic [3:0]       hit;
    logic [3:0]       miss;
    logic [3:0]       conf;
    logic [3:0][63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  msrh_l1d_rd_bank_arb_if #(.REQ_N(REQ_N), .BANK_N(BANK_N), .PADDR_W(PADDR_W), .DATA_W(DATA_W)) bus();

  msrh_l1d_rd_bank_arb #(
    .REQ_N(REQ_N), .BANK_N(BANK_N), .PADDR_W(PADDR_W), .LINE_OFFSET_W(6),
    .DATA_W(DATA_W), .STARVE_MAX(3)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ((|bus.o_s1_hit) || (|bus.o_s1_miss) || (|bus.o_s1_conflict) || (|bus.o_s1_data))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_s1: hit=%b miss=%b conflict=%b with no response expected",
                 bus.o_s1_hit, bus.o_s1_miss, bus.o_s1_conflict);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("s1_hit", bus.o_s1_hit, e.hit);
        chk("s1_miss", bus.o_s1_miss, e.miss);
        chk("s1_conflict", bus.o_s1_conflict, e.conf);
        chk("s1_data", bus.o_s1_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic clear_s0();
    bus.i_s0_valid = '0;
    bus.i_s0_h_pri = '0;
    bus.i_s0_paddr = '0;
  endtask

  task automatic idle();
    clear_s0();
    @(posedge clk);
    #1;
  endtask

  // Drives one s0 cycle, checks the bank-side s0 outputs, then applies this request's bank s1 response.
  task automatic issue(input logic [3:0] vld, input logic [3:0] hp,
                       input logic [39:0] a0, input logic [39:0] a1,
                       input logic [39:0] a2, input logic [39:0] a3,
                       input logic [1:0] bvld, input logic [39:0] bpa0, input logic [39:0] bpa1,
                       input logic [1:0] bhit, input logic [1:0] bmiss,
                       input logic [3:0] ehit, input logic [3:0] emiss, input logic [3:0] econf);
    exp_t e;
    logic [39:0] a [4];
    a = '{a0, a1, a2, a3};
    bus.i_s0_valid = vld;
    bus.i_s0_h_pri = hp;
    for (int r = 0; r < 4; r++) bus.i_s0_paddr[r] = a[r];
    e.hit  = ehit;
    e.miss = emiss;
    e.conf = econf;
    for (int r = 0; r < 4; r++) e.data[r] = (ehit[r] | emiss[r]) ? (a[r][6] ? D1 : D0) : 64'h0;
    q.push_back(e);
    #1;
    chk("bank_s0_valid", bus.o_bank_s0_valid, bvld);
    chk("bank0_s0_paddr", bus.o_bank_s0_paddr[0], bpa0);
    chk("bank1_s0_paddr", bus.o_bank_s0_paddr[1], bpa1);
    @(posedge clk);
    #1;
    bus.i_bank_s1_hit  = bhit;
    bus.i_bank_s1_miss = bmiss;
    clear_s0();
  endtask

  initial begin
    clear_s0();
    bus.i_bank_s1_hit  = 2'b11;
    bus.i_bank_s1_miss = 2'b00;
    bus.i_bank_s1_data = {D1, D0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("rst_hit", bus.o_s1_hit, 4'b0);
    chk("rst_miss", bus.o_s1_miss, 4'b0);
    chk("rst_conflict", bus.o_s1_conflict, 4'b0);
    chk("rst_data", bus.o_s1_data, 256'h0);

    // h_pri beats round-robin and leaves rr_ptr[0] at 0, so REQ1 then wins over REQ3
    issue(4'b0101, 4'b0100, 40'h1000, 40'h0, 40'h3000, 40'h0, 2'b01, 40'h3000, 40'h0, 2'b11, 2'b00, 4'b0100, 4'b0, 4'b0001);
    issue(4'b1010, 4'b0000, 40'h0, 40'h2000, 40'h0, 40'h4000, 2'b01, 40'h2000, 40'h0, 2'b11, 2'b00, 4'b0010, 4'b0, 4'b1000);
    // rr_ptr[0]=2: wrap to REQ0, then REQ1 retries, then all four contend with rr_ptr[0]=2
    issue(4'b0011, 4'b0000, 40'h1000, 40'h2000, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0001, 4'b0, 4'b0010);
    issue(4'b0010, 4'b0000, 40'h0, 40'h2000, 40'h0, 40'h0, 2'b01, 40'h2000, 40'h0, 2'b11, 2'b00, 4'b0010, 4'b0, 4'b0000);
    issue(4'b1111, 4'b0000, 40'h1000, 40'h2000, 40'h3000, 40'h4000, 2'b01, 40'h3000, 40'h0, 2'b11, 2'b00, 4'b0100, 4'b0, 4'b1011);
    idle();

    // starvation: REQ1 loses three times to h_pri REQ0, wins the fourth, then its counter is back to 0
    for (int i = 0; i < 3; i++)
      issue(4'b0011, 4'b0001, 40'h1000, 40'h2000, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0001, 4'b0, 4'b0010);
    issue(4'b0011, 4'b0001, 40'h1000, 40'h2000, 40'h0, 40'h0, 2'b01, 40'h2000, 40'h0, 2'b11, 2'b00, 4'b0010, 4'b0, 4'b0001);
    issue(4'b0011, 4'b0001, 40'h1000, 40'h2000, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0001, 4'b0, 4'b0010);
    idle();

    // two banks in the same cycle, first both hit, then bank 1 misses
    issue(4'b0011, 4'b0000, 40'h1000, 40'h1040, 40'h0, 40'h0, 2'b11, 40'h1000, 40'h1040, 2'b11, 2'b00, 4'b0011, 4'b0, 4'b0000);
    issue(4'b0011, 4'b0000, 40'h1000, 40'h1040, 40'h0, 40'h0, 2'b11, 40'h1000, 40'h1040, 2'b01, 2'b10, 4'b0001, 4'b0010, 4'b0000);
    // REQ3 alone moves rr_ptr[0] back to 0
    issue(4'b1000, 4'b0000, 40'h0, 40'h0, 40'h0, 40'h4000, 2'b01, 40'h4000, 40'h0, 2'b11, 2'b00, 4'b1000, 4'b0, 4'b0000);
`ifdef MSRH_L1D_RD_MERGE_EN
    issue(4'b0011, 4'b0000, 40'h1000, 40'h1008, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0011, 4'b0, 4'b0000);
`else
    issue(4'b0011, 4'b0000, 40'h1000, 40'h1008, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0001, 4'b0, 4'b0010);
`endif
    // two h_pri requesters on one bank: lowest index wins
    issue(4'b1010, 4'b1010, 40'h0, 40'h2000, 40'h0, 40'h4000, 2'b01, 40'h2000, 40'h0, 2'b11, 2'b00, 4'b0010, 4'b0, 4'b1000);
    idle();

    // reset while a hit is outstanding in s1 drops it asynchronously
    bus.i_s0_valid = 4'b0001;
    bus.i_s0_paddr[0] = 40'h1000;
    @(posedge clk);
    #1;
    bus.i_bank_s1_hit = 2'b11;
    clear_s0();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hit", bus.o_s1_hit, 4'b0);
    chk("midrst_miss", bus.o_s1_miss, 4'b0);
    chk("midrst_conflict", bus.o_s1_conflict, 4'b0);
    chk("midrst_data", bus.o_s1_data, 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    issue(4'b0001, 4'b0000, 40'h1000, 40'h0, 40'h0, 40'h0, 2'b01, 40'h1000, 40'h0, 2'b11, 2'b00, 4'b0001, 4'b0, 4'b0000);
    idle();
    idle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_s1: %0d expected responses never appeared, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
